alu_mc: RTL and testbench
=========================

ALU_MC -- requirements
Module: alu_mc

Interface
REQ-001 SHALL have parameters: NUM_CH 2 (channels processed per frame); DATA_W 16 (sample width); GUARD_W 8 (accumulator guard bits); FRAC_W 16 (accumulator fraction bits); DATA_DEPTH 256 (history words per channel); COEFF_DEPTH 256 (coeff words per channel); NUM_RJ 16 (rj groups per channel); RJ_W 8 (rj width).
REQ-002 SHALL have ports, in order: clk in 1 (clock); clear_n in 1 (reset); start in 1 (frame request); cur_addr in log2(DATA_DEPTH) (newest-sample offset); cur_n in 16 (newest-sample index since stream start); data in DATA_W; coeff_data in 16; rj_data in RJ_W; data_addr out log2(NUM_CH*DATA_DEPTH); coeff_addr out log2(NUM_CH*COEFF_DEPTH); rj_addr out log2(NUM_CH*NUM_RJ); busy out 1; out_valid out 1; out_ready in 1; out_ch out log2(NUM_CH); accum_reg out ACC_W=GUARD_W+DATA_W+FRAC_W; ovf out 1.
REQ-003 SHALL use one clock, clk; reset clear_n SHALL be asynchronous and active-low.
REQ-004 Memory reads SHALL be combinational: data/coeff_data/rj_data valid in the same cycle as their address.

Function
REQ-005 States SHALL be IDLE, LOAD_RJ, MAC, SHIFT, OUT.
REQ-006 IDLE: start=1 latches cur_addr/cur_n, sets ch=0, j=NUM_RJ-1, coeff index=0, acc=0 -> LOAD_RJ; start while not IDLE SHALL be ignored.
REQ-007 busy SHALL be 1 in every state except IDLE.
REQ-008 LOAD_RJ: rj_addr=ch*NUM_RJ+j; latch rj_data as remaining count; count 0 -> SHIFT, else -> MAC.
REQ-009 MAC (one term per cycle): coeff_addr=ch*COEFF_DEPTH+index; k=coeff_data[7:0], sign=coeff_data[8]; data_addr=ch*DATA_DEPTH+((cur_addr-k) mod DATA_DEPTH); acc += or -= operand; index++; count--; last term -> SHIFT.
REQ-010 Operand SHALL be data sign-extended by GUARD_W bits and left-shifted by FRAC_W; if k > latched cur_n operand SHALL be zero (pre-stream history).
REQ-011 SHIFT: acc = acc arithmetic-right-shift 1; j>0 -> j--, LOAD_RJ; j=0 -> OUT.
REQ-012 Coefficient bank SHALL be laid out in processing order: group NUM_RJ-1 first, group 0 last.
REQ-013 OUT: out_valid=1, accum_reg=acc, out_ch=ch, all held stable until out_ready=1; on handshake: ch<NUM_CH-1 -> ch++, j=NUM_RJ-1, index=0, acc=0, LOAD_RJ; else -> IDLE.
REQ-014 Latency start -> first out_valid SHALL be 1+sum over j of (2+rj_j) cycles; out_ready held 1 adds one cycle per channel.
REQ-015 Index wrap SHALL be modulo COEFF_DEPTH; cur_addr-k SHALL wrap modulo DATA_DEPTH.
REQ-016 Arithmetic SHALL be ACC_W two's complement; without saturation, overflow wraps.

Reset
REQ-017 clear_n=0 SHALL force IDLE, acc=0, all counters 0, busy=0, out_valid=0, out_ch=0, accum_reg=0, ovf=0, all addresses 0, at any time including mid-frame.

Configuration
REQ-018 ALU_MC_SAT_EN defined: MAC adds clamp to ACC_W max/min, ovf sets sticky on any clamp, cleared on start in IDLE; undefined: adds wrap, ovf tied 0.

Structure
REQ-019 Package alu_mc_pkg SHALL hold the state enum, ACC_W derivation function, and coeff field constants (sign bit 8, delay bits 7:0).
REQ-020 Sub-module alu_mc_addsat (ACC_W add/sub with optional clamp) SHALL be the sole adder.

Verification
REQ-021 All rj=0, start -> out_valid at cycle 33, accum_reg=0, ch 0 then 1.
REQ-022 rj[0]=1 only, coeff 0x000, cur_n=5, x=0x4000 -> accum_reg=0x0020000000.
REQ-023 Coeff 0x103 (negative, k=3), cur_addr=1, cur_n=10 -> data_addr wraps to 254 (ch0) and 510 (ch1), term subtracted.
REQ-024 k=3, cur_n=2 -> operand zero, accum_reg=0.
REQ-025 out_ready=0 for 10 cycles -> out_valid/accum_reg stable; start pulses meanwhile ignored.
REQ-026 clear_n low mid-MAC -> all outputs 0 next sample; with ALU_MC_SAT_EN, 300 terms of 0x7FFF -> accum clamps, ovf=1.

Source files
------------

// File: rtl/alu_mc_pkg.sv
// Shared state encoding, accumulator width helper and coefficient field layout for alu_mc.
package alu_mc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_RJ,
        MAC,
        SHIFT,
        OUT
    } state_t;

    localparam int unsigned COEFF_SIGN_BIT = 8;
    localparam int unsigned COEFF_K_MSB    = 7;
    localparam int unsigned COEFF_K_W      = COEFF_K_MSB + 1;

    function automatic int unsigned acc_width(input int unsigned guard_w,
                                              input int unsigned data_w,
                                              input int unsigned frac_w);
        return guard_w + data_w + frac_w;
    endfunction

endpackage

// File: rtl/alu_mc_addsat.sv
// Accumulator add/subtract for alu_mc; with ALU_MC_SAT_EN defined the result clamps to the
// signed ACC_W range and o_clamp flags it, otherwise the result wraps and o_clamp is 0.
module alu_mc_addsat #(
    parameter int unsigned ACC_W = 40
) (
    input  logic [ACC_W-1:0] i_a,
    input  logic [ACC_W-1:0] i_b,
    input  logic             i_sub,
    output logic [ACC_W-1:0] o_sum,
    output logic             o_clamp
);

`ifdef ALU_MC_SAT_EN
    logic [ACC_W:0] w_ext;
    logic           w_ovf;

    // One extra bit keeps the exact result; overflow shows as disagreeing top bits.
    assign w_ext = i_sub ? ({i_a[ACC_W-1], i_a} - {i_b[ACC_W-1], i_b})
                         : ({i_a[ACC_W-1], i_a} + {i_b[ACC_W-1], i_b});
    assign w_ovf = w_ext[ACC_W] ^ w_ext[ACC_W-1];

    always_comb begin
        o_sum   = w_ext[ACC_W-1:0];
        o_clamp = 1'b0;
        if (w_ovf) begin
            o_clamp = 1'b1;
            o_sum   = w_ext[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end
`else
    assign o_sum   = i_sub ? (i_a - i_b) : (i_a + i_b);
    assign o_clamp = 1'b0;
`endif

endmodule

// File: rtl/alu_mc.sv
// Multichannel delayed-tap MAC: per channel, NUM_RJ groups of signed taps, halving after each group.
// Optional saturating accumulation and sticky ovf when ALU_MC_SAT_EN is defined.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int unsigned NUM_CH      = 2,
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned GUARD_W     = 8,
    parameter int unsigned FRAC_W      = 16,
    parameter int unsigned DATA_DEPTH  = 256,
    parameter int unsigned COEFF_DEPTH = 256,
    parameter int unsigned NUM_RJ      = 16,
    parameter int unsigned RJ_W        = 8,
    localparam int unsigned ACC_W = acc_width(GUARD_W, DATA_W, FRAC_W),
    localparam int unsigned CA_W  = $clog2(DATA_DEPTH),
    localparam int unsigned DA_W  = $clog2(NUM_CH * DATA_DEPTH),
    localparam int unsigned KA_W  = $clog2(NUM_CH * COEFF_DEPTH),
    localparam int unsigned RA_W  = $clog2(NUM_CH * NUM_RJ),
    localparam int unsigned CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              start,
    input  logic [CA_W-1:0]   cur_addr,
    input  logic [15:0]       cur_n,
    input  logic [DATA_W-1:0] data,
    input  logic [15:0]       coeff_data,
    input  logic [RJ_W-1:0]   rj_data,
    output logic [DA_W-1:0]   data_addr,
    output logic [KA_W-1:0]   coeff_addr,
    output logic [RA_W-1:0]   rj_addr,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CH_W-1:0]   out_ch,
    output logic [ACC_W-1:0]  accum_reg,
    output logic              ovf
);

    localparam int unsigned J_W  = (NUM_RJ > 1) ? $clog2(NUM_RJ) : 1;
    localparam int unsigned IX_W = (COEFF_DEPTH > 1) ? $clog2(COEFF_DEPTH) : 1;

    state_t            r_state, w_state_nxt;
    logic [CA_W-1:0]   r_cur_addr, w_cur_addr_nxt;
    logic [15:0]       r_cur_n, w_cur_n_nxt;
    logic [CH_W-1:0]   r_ch, w_ch_nxt;
    logic [J_W-1:0]    r_j, w_j_nxt;
    logic [IX_W-1:0]   r_idx, w_idx_nxt;
    logic [RJ_W-1:0]   r_cnt, w_cnt_nxt;
    logic [ACC_W-1:0]  r_acc, w_acc_nxt;
    logic              r_ovf, w_ovf_nxt;
    logic              r_busy, r_out_valid;
    logic [CH_W-1:0]   r_out_ch;
    logic [ACC_W-1:0]  r_accum_reg;

    logic [COEFF_K_W-1:0] w_k;
    logic                 w_neg;
    logic [CA_W-1:0]      w_hist;
    logic                 w_pre_stream;
    logic [ACC_W-1:0]     w_op;
    logic [ACC_W-1:0]     w_sum;
    logic                 w_clamp;
    logic [DA_W-1:0]      w_data_addr;
    logic [KA_W-1:0]      w_coeff_addr;
    logic [RA_W-1:0]      w_rj_addr;
    logic                 w_unused;

    // Tap decode: delay k back from the newest sample; taps older than the stream contribute 0.
    assign w_k          = coeff_data[COEFF_K_MSB:0];
    assign w_neg        = coeff_data[COEFF_SIGN_BIT];
    assign w_hist       = r_cur_addr - CA_W'(w_k);
    assign w_pre_stream = 16'(w_k) > r_cur_n;
    assign w_op         = w_pre_stream ? '0 : {{GUARD_W{data[DATA_W-1]}}, data, {FRAC_W{1'b0}}};
    assign w_unused     = &{1'b0, coeff_data[15:COEFF_SIGN_BIT+1]};

    alu_mc_addsat #(
        .ACC_W (ACC_W)
    ) u_addsat (
        .i_a     (r_acc),
        .i_b     (w_op),
        .i_sub   (w_neg),
        .o_sum   (w_sum),
        .o_clamp (w_clamp)
    );

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cur_addr_nxt = r_cur_addr;
        w_cur_n_nxt    = r_cur_n;
        w_ch_nxt       = r_ch;
        w_j_nxt        = r_j;
        w_idx_nxt      = r_idx;
        w_cnt_nxt      = r_cnt;
        w_acc_nxt      = r_acc;
        w_ovf_nxt      = r_ovf;
        w_data_addr    = '0;
        w_coeff_addr   = '0;
        w_rj_addr      = '0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_cur_addr_nxt = cur_addr;
                    w_cur_n_nxt    = cur_n;
                    w_ch_nxt       = '0;
                    w_j_nxt        = J_W'(NUM_RJ - 1);
                    w_idx_nxt      = '0;
                    w_acc_nxt      = '0;
                    w_ovf_nxt      = 1'b0;
                    w_state_nxt    = LOAD_RJ;
                end
            end
            LOAD_RJ: begin
                w_rj_addr   = RA_W'(r_ch) * RA_W'(NUM_RJ) + RA_W'(r_j);
                w_cnt_nxt   = rj_data;
                w_state_nxt = (rj_data == '0) ? SHIFT : MAC;
            end
            MAC: begin
                w_coeff_addr = KA_W'(r_ch) * KA_W'(COEFF_DEPTH) + KA_W'(r_idx);
                w_data_addr  = DA_W'(r_ch) * DA_W'(DATA_DEPTH) + DA_W'(w_hist);
                w_acc_nxt    = w_sum;
                w_ovf_nxt    = r_ovf | w_clamp;
                w_idx_nxt    = r_idx + IX_W'(1);
                w_cnt_nxt    = r_cnt - RJ_W'(1);
                if (r_cnt == RJ_W'(1)) begin
                    w_state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                w_acc_nxt = {r_acc[ACC_W-1], r_acc[ACC_W-1:1]};
                if (r_j != '0) begin
                    w_j_nxt     = r_j - J_W'(1);
                    w_state_nxt = LOAD_RJ;
                end else begin
                    w_state_nxt = OUT;
                end
            end
            OUT: begin
                if (out_ready) begin
                    if (r_ch != CH_W'(NUM_CH - 1)) begin
                        w_ch_nxt    = r_ch + CH_W'(1);
                        w_j_nxt     = J_W'(NUM_RJ - 1);
                        w_idx_nxt   = '0;
                        w_acc_nxt   = '0;
                        w_state_nxt = LOAD_RJ;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Datapath and registered outputs; the result is captured once on entry to OUT and held.
    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_cur_addr  <= '0;
            r_cur_n     <= '0;
            r_ch        <= '0;
            r_j         <= '0;
            r_idx       <= '0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_ovf       <= 1'b0;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_ch    <= '0;
            r_accum_reg <= '0;
        end else begin
            r_cur_addr  <= w_cur_addr_nxt;
            r_cur_n     <= w_cur_n_nxt;
            r_ch        <= w_ch_nxt;
            r_j         <= w_j_nxt;
            r_idx       <= w_idx_nxt;
            r_cnt       <= w_cnt_nxt;
            r_acc       <= w_acc_nxt;
            r_ovf       <= w_ovf_nxt;
            r_busy      <= (w_state_nxt != IDLE);
            r_out_valid <= (w_state_nxt == OUT);
            if (r_state == SHIFT && w_state_nxt == OUT) begin
                r_accum_reg <= w_acc_nxt;
                r_out_ch    <= r_ch;
            end
        end
    end

    assign data_addr  = w_data_addr;
    assign coeff_addr = w_coeff_addr;
    assign rj_addr    = w_rj_addr;
    assign busy       = r_busy;
    assign out_valid  = r_out_valid;
    assign out_ch     = r_out_ch;
    assign accum_reg  = r_accum_reg;
    assign ovf        = r_ovf;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed frames plus randomized memories checked against a
// behavioural model of the grouped tap sum. Define ALU_MC_SAT_EN to exercise the clamping build.
module tb_alu_mc;

    logic        clk = 1'b0;
    logic        clear_n;
    logic        start;
    logic [7:0]  cur_addr;
    logic [15:0] cur_n;
    logic [15:0] data;
    logic [15:0] coeff_data;
    logic [7:0]  rj_data;
    logic [8:0]  data_addr;
    logic [8:0]  coeff_addr;
    logic [4:0]  rj_addr;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [0:0]  out_ch;
    logic [39:0] accum_reg;
    logic        ovf;

    logic [15:0] data_mem  [512];
    logic [15:0] coeff_mem [512];
    logic [7:0]  rj_mem    [32];
    logic [8:0]  seen_da   [2];

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign data       = data_mem[data_addr];
    assign coeff_data = coeff_mem[coeff_addr];
    assign rj_data    = rj_mem[rj_addr];

    alu_mc dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .start      (start),
        .cur_addr   (cur_addr),
        .cur_n      (cur_n),
        .data       (data),
        .coeff_data (coeff_data),
        .rj_data    (rj_data),
        .data_addr  (data_addr),
        .coeff_addr (coeff_addr),
        .rj_addr    (rj_addr),
        .busy       (busy),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_ch     (out_ch),
        .accum_reg  (accum_reg),
        .ovf        (ovf)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mems();
        foreach (data_mem[i])  data_mem[i]  = '0;
        foreach (coeff_mem[i]) coeff_mem[i] = '0;
        foreach (rj_mem[i])    rj_mem[i]    = '0;
    endtask

    // Reference: walk groups NUM_RJ-1..0 in coefficient order, summing signed shifted taps, halve per group.
    function automatic logic [39:0] model(input int ch, input int ca, input int cn, output bit clamped);
        longint acc;
        longint op;
        longint lim_hi;
        longint lim_lo;
        int     idx;
        int     k;
        logic [15:0] c;
        acc     = 0;
        idx     = 0;
        clamped = 1'b0;
        lim_hi  = (longint'(1) <<< 39) - 1;
        lim_lo  = -(longint'(1) <<< 39);
        for (int j = 15; j >= 0; j--) begin
            for (int t = 0; t < int'(rj_mem[ch*16 + j]); t++) begin
                c = coeff_mem[ch*256 + idx];
                k = int'(c[7:0]);
                if (k > cn) op = 0;
                else op = longint'($signed(data_mem[ch*256 + ((ca - k) & 255)])) * 65536;
                acc = c[8] ? acc - op : acc + op;
`ifdef ALU_MC_SAT_EN
                if (acc > lim_hi) begin
                    acc = lim_hi;
                    clamped = 1'b1;
                end else if (acc < lim_lo) begin
                    acc = lim_lo;
                    clamped = 1'b1;
                end
`else
                acc = (acc <<< 24) >>> 24;
`endif
                idx = (idx + 1) % 256;
            end
            acc = acc >>> 1;
        end
        return acc[39:0];
    endfunction

    // One full frame: start, per-channel result checks, optional backpressure hold on channel 0.
    task automatic run_frame(input string tag, input logic [7:0] ca, input logic [15:0] cn, input int hold);
        int          cyc;
        int          lat;
        bit          clamp_c;
        bit          frame_ovf;
        bit          stable;
        logic [39:0] exp_acc;
        logic [8:0]  last_da;
        frame_ovf = 1'b0;
        lat = 1;
        for (int j = 0; j < 16; j++) lat += 2 + int'(rj_mem[j]);
        out_ready = (hold == 0);
        cur_addr  = ca;
        cur_n     = cn;
        start     = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        for (int ch = 0; ch < 2; ch++) begin
            last_da = '0;
            while (!out_valid && cyc < 4000) begin
                if (data_addr != '0) last_da = data_addr;
                tick();
                cyc++;
            end
            seen_da[ch] = last_da;
            exp_acc = model(ch, int'(ca), int'(cn), clamp_c);
            frame_ovf |= clamp_c;
            if (ch == 0) check({tag, "_latency"}, 64'(cyc), 64'(lat));
            check({tag, "_valid"}, 64'(out_valid), 64'(1));
            check({tag, "_ch"},    64'(out_ch),    64'(ch));
            check({tag, "_acc"},   64'(accum_reg), 64'(exp_acc));
            check({tag, "_ovf"},   64'(ovf),       64'(frame_ovf));
            if (hold > 0 && ch == 0) begin
                stable = 1'b1;
                for (int i = 0; i < hold; i++) begin
                    start    = ~start;
                    cur_addr = ca ^ 8'h55;
                    tick();
                    if (out_valid !== 1'b1 || accum_reg !== exp_acc || out_ch !== 1'b0) stable = 1'b0;
                end
                start = 1'b0;
                check({tag, "_hold_stable"}, 64'(stable), 64'(1));
                check({tag, "_hold_busy"},   64'(busy),   64'(1));
                out_ready = 1'b1;
            end
            tick();
            cyc++;
        end
        check({tag, "_idle"}, 64'(busy), 64'(0));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},  64'(busy),       64'(0));
        check({tag, "_valid"}, 64'(out_valid),  64'(0));
        check({tag, "_ch"},    64'(out_ch),     64'(0));
        check({tag, "_acc"},   64'(accum_reg),  64'(0));
        check({tag, "_ovf"},   64'(ovf),        64'(0));
        check({tag, "_daddr"}, 64'(data_addr),  64'(0));
        check({tag, "_kaddr"}, 64'(coeff_addr), 64'(0));
        check({tag, "_raddr"}, 64'(rj_addr),    64'(0));
    endtask

    initial begin
        clear_n   = 1'b0;
        start     = 1'b0;
        out_ready = 1'b1;
        cur_addr  = '0;
        cur_n     = '0;
        clear_mems();
        #12;
        check_all_zero("reset");
        #3;
        clear_n = 1'b1;
        tick();

        // All groups empty: 1 + 16*2 cycles, zero result on both channels.
        run_frame("rj_zero", 8'd0, 16'd0, 0);

        // Single add tap in group 0 of each channel.
        rj_mem[0] = 8'd1;
        rj_mem[16] = 8'd1;
        data_mem[7] = 16'h4000;
        data_mem[256 + 7] = 16'h4000;
        run_frame("single_tap", 8'd7, 16'd5, 0);
        check("single_tap_const", 64'(accum_reg), 64'(40'h0020000000));

        // Negative tap reaching behind address 0.
        coeff_mem[0] = 16'h0103;
        coeff_mem[256] = 16'h0103;
        data_mem[254] = 16'h0100;
        data_mem[510] = 16'h0200;
        run_frame("wrap", 8'd1, 16'd10, 0);
        check("wrap_da_ch0", 64'(seen_da[0]), 64'(254));
        check("wrap_da_ch1", 64'(seen_da[1]), 64'(510));
        check("wrap_const",  64'(accum_reg),  64'(40'hFFFF000000));

        // Tap older than the stream start contributes nothing.
        coeff_mem[0] = 16'h0003;
        coeff_mem[256] = 16'h0003;
        data_mem[7] = 16'h1234;
        data_mem[263] = 16'h1234;
        run_frame("pre_stream", 8'd10, 16'd2, 0);
        check("pre_stream_const", 64'(accum_reg), 64'(0));

        // Backpressure with start pulses and a changing cur_addr while holding.
        data_mem[7] = 16'h0F00;
        data_mem[263] = 16'hF100;
        run_frame("hold", 8'd10, 16'd3, 10);

        // Randomized memories and stream positions.
        for (int r = 0; r < 6; r++) begin
            foreach (data_mem[i])  data_mem[i]  = 16'($urandom);
            foreach (coeff_mem[i]) coeff_mem[i] = 16'($urandom_range(0, 511));
            foreach (rj_mem[i])    rj_mem[i]    = 8'($urandom_range(0, 4));
            run_frame($sformatf("rand%0d", r), 8'($urandom), 16'($urandom_range(0, 300)), 0);
        end

        // 300 large positive taps: clamps with saturation, wraps without.
        clear_mems();
        rj_mem[1] = 8'd45;
        rj_mem[0] = 8'd255;
        rj_mem[17] = 8'd45;
        rj_mem[16] = 8'd255;
        data_mem[0] = 16'h7FFF;
        data_mem[256] = 16'h7FFF;
        run_frame("big", 8'd0, 16'd100, 0);
`ifdef ALU_MC_SAT_EN
        check("big_sat_const", 64'(accum_reg), 64'(40'h3FFFFFFFFF));
        check("big_sat_ovf",   64'(ovf),       64'(1));
`endif

        // Next frame starts with ovf cleared and a nonzero result so reset is visible.
        clear_mems();
        rj_mem[0] = 8'd1;
        rj_mem[16] = 8'd1;
        data_mem[3] = 16'h2222;
        data_mem[259] = 16'h2222;
        run_frame("after_big", 8'd3, 16'd9, 0);

        // Asynchronous clear in the middle of a long MAC run.
        rj_mem[15] = 8'd100;
        cur_addr = 8'd3;
        cur_n = 16'd9;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        check("midmac_busy", 64'(busy), 64'(1));
        #2;
        clear_n = 1'b0;
        #1;
        check_all_zero("midmac_reset");
        #3;
        clear_n = 1'b1;
        repeat (3) tick();
        check("midmac_stays_idle", 64'(busy), 64'(0));
        run_frame("recover", 8'd3, 16'd9, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
